// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with NUM_CS active-low chip selects, all four
// CPOL/CPHA modes, a programmable half-period divider and a sticky
// transfer-complete interrupt.
// Optional build macro: SPI_MASTER_MULTI_LOOPBACK_EN adds a LoopBack input
// that routes SPI_MOSI into the receive path in place of SPI_MISO.
module spi_master_multi #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] TxData,
  input  logic              Start,
  input  logic [SEL_W-1:0]  CsSel,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [DIV_W-1:0]  ClkDiv,
  input  logic              IrqEnable,
  input  logic              IrqClear,
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  input  logic              LoopBack,
`endif
  input  logic              SPI_MISO,
  output logic [DATA_W-1:0] RxData,
  output logic              Busy,
  output logic              Done,
  output logic              IrqPending,
  output logic              Irq,
  output logic              SPI_CLK,
  output logic              SPI_MOSI,
  output logic [NUM_CS-1:0] SPI_CS
);

  localparam int EW = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic [EW-1:0]     edge_cnt;
  logic              cpol_q;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_data_q;
  logic [NUM_CS-1:0] cs_q;
  logic [NUM_CS-1:0] cs_dec;
  logic              sclk_q;
  logic              mosi_q;
  logic              done_q;
  logic              pend_q;
  logic              half_end;
  logic              last_edge;
  logic              accept;
  logic              leading;
  logic              shift_now;
  logic              miso_in;

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
  assign miso_in = LoopBack ? mosi_q : SPI_MISO;
`else
  assign miso_in = SPI_MISO;
`endif

  // Half-period boundary, edge position and shift/sample selection.
  always_comb begin
    half_end  = (cnt == div_q);
    last_edge = (edge_cnt == EW'(2 * DATA_W - 1));
    // Even edge indices move SPI_CLK away from its idle level (leading edges).
    leading   = ~edge_cnt[0];
    // CPHA=0 shifts on trailing edges, CPHA=1 on leading edges; the other edge samples.
    shift_now = (leading == cpha_q);
  end

  // Chip-select decode; an out-of-range index selects nothing.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(CsSel) == i) cs_dec[i] = 1'b0;
    end
  end

  // Next-state logic; Start is only honoured in IDLE and is never queued.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: if (half_end) state_next = SHIFT;
      SHIFT: if (half_end && last_edge) state_next = HOLD;
      HOLD:  if (half_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  // Half-period counter, restarted at every boundary and held at zero in IDLE.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset)                         cnt <= '0;
    else if (state == IDLE || half_end) cnt <= '0;
    else                                cnt <= cnt + DIV_W'(1);
  end

  // SPI_CLK edge counter within SHIFT.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset)                 edge_cnt <= '0;
    else if (state != SHIFT)    edge_cnt <= '0;
    else if (half_end)          edge_cnt <= edge_cnt + EW'(1);
  end

  // Transfer datapath: latch configuration on accept, then shift/sample per edge.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_data_q <= '0;
      cs_q      <= '1;
    end else if (accept) begin
      cpol_q <= CPOL;
      cpha_q <= CPHA;
      div_q  <= ClkDiv;
      sclk_q <= CPOL;
      mosi_q <= TxData[DATA_W-1];
      // CPHA=0 presents the MSB now; CPHA=1 presents it on the first leading edge.
      tx_sh  <= CPHA ? TxData : {TxData[DATA_W-2:0], 1'b0};
      cs_q   <= cs_dec;
    end else if (state == SHIFT && half_end) begin
      sclk_q <= ~sclk_q;
      if (shift_now) begin
        mosi_q <= tx_sh[DATA_W-1];
        tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
      end else begin
        rx_sh  <= {rx_sh[DATA_W-2:0], miso_in};
      end
    end else if (state == HOLD && half_end) begin
      cs_q      <= '1;
      rx_data_q <= rx_sh;
    end
  end

  // Done pulse in the first IDLE cycle after HOLD.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) done_q <= 1'b0;
    else        done_q <= (state == HOLD) && half_end;
  end

  // Sticky completion flag; a Done in the same cycle as IrqClear keeps it set.
  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) pend_q <= 1'b0;
    else        pend_q <= done_q | (pend_q & ~IrqClear);
  end

  assign Busy       = (state != IDLE);
  assign Done       = done_q;
  assign RxData     = rx_data_q;
  assign IrqPending = pend_q;
  assign Irq        = pend_q & IrqEnable;
  assign SPI_CLK    = sclk_q;
  assign SPI_MOSI   = mosi_q;
  assign SPI_CS     = cs_q;

endmodule

// File: doc/spi_master_multi.md
SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, meaning the transfer word width in bits (range 4..32).
REQ-002 The block SHALL provide parameter NUM_CS, default 4, meaning the number of active-low chip-select outputs (range 1..8).
REQ-003 The block SHALL provide parameter DIV_W, default 8, meaning the width of the clock divider input.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, as listed below.
REQ-005 Ports SHALL be:
  MasterCLK   in   1                   system clock; all logic on its rising edge
  Reset       in   1                   asynchronous, active-low reset
  TxData      in   DATA_W              word to transmit, sampled on an accepted Start
  Start       in   1                   single-cycle transfer request
  CsSel       in   max(1,clog2(NUM_CS)) index of the chip select to assert
  CPOL        in   1                   SPI clock idle level
  CPHA        in   1                   SPI clock phase
  ClkDiv      in   DIV_W               half-period of SPI_CLK minus one, in MasterCLK cycles
  IrqEnable   in   1                   interrupt mask
  IrqClear    in   1                   clears IrqPending
  SPI_MISO    in   1                   serial data from the slave
  RxData      out  DATA_W              last received word
  Busy        out  1                   transfer in progress
  Done        out  1                   one-cycle pulse at the end of a transfer
  IrqPending  out  1                   sticky transfer-complete event
  Irq         out  1                   IrqPending AND IrqEnable
  SPI_CLK     out  1                   serial clock
  SPI_MOSI    out  1                   serial data to the slave
  SPI_CS      out  NUM_CS              chip selects, active-low

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, SHIFT and HOLD, with transitions IDLE->SETUP on an accepted Start, SETUP->SHIFT after one half-period, SHIFT->HOLD after 2*DATA_W half-periods, and HOLD->IDLE after one half-period.
REQ-007 One half-period SHALL be ClkDiv+1 MasterCLK cycles; ClkDiv=0 SHALL give SPI_CLK = MasterCLK/2.
REQ-008 Start SHALL be accepted only in IDLE; on acceptance the block SHALL latch TxData, CsSel, CPOL, CPHA and ClkDiv, and input changes during a transfer SHALL have no effect.
REQ-009 Start asserted while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-010 Busy SHALL be high from the cycle after the accepted Start through the last HOLD cycle, for exactly (2*DATA_W+2)*(ClkDiv+1) cycles.
REQ-011 SPI_CS[CsSel] SHALL be low during SETUP, SHIFT and HOLD, and all other SPI_CS bits SHALL stay high; a CsSel >= NUM_CS SHALL assert no chip select while the transfer still runs.
REQ-012 SPI_CLK SHALL rest at the latched CPOL outside SHIFT and SHALL toggle at each half-period boundary in SHIFT, giving DATA_W full cycles.
REQ-013 Data SHALL be transmitted MSB first.
REQ-014 With CPHA=0, SPI_MOSI SHALL be valid from SETUP entry, MISO SHALL be sampled on leading edges, and MOSI SHALL shift on trailing edges.
REQ-015 With CPHA=1, MOSI SHALL shift on leading edges and MISO SHALL be sampled on trailing edges.
REQ-016 RxData SHALL update in the same cycle Done pulses, and SHALL hold its value otherwise.
REQ-017 Done SHALL pulse high for exactly one cycle on the HOLD->IDLE transition, coincident with Busy falling.
REQ-018 A new Start in the cycle Done is high SHALL be accepted.
REQ-019 IrqPending SHALL set on Done and clear on IrqClear; if both occur in the same cycle, the set SHALL win.
REQ-020 Irq SHALL be combinational: IrqPending & IrqEnable.

Reset
REQ-021 Reset low SHALL immediately, without waiting for a clock, force the FSM to IDLE and set Busy=0, Done=0, IrqPending=0, RxData=0, SPI_CLK=0, SPI_MOSI=0 and SPI_CS all ones.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no Done pulse and no IrqPending set.
REQ-023 Latched CPOL SHALL reset to 0.

Configuration
REQ-024 When macro SPI_MASTER_MULTI_LOOPBACK_EN is defined, the block SHALL add input port LoopBack (1 bit); while LoopBack=1 the receive path SHALL take SPI_MOSI internally instead of SPI_MISO.
REQ-025 When SPI_MASTER_MULTI_LOOPBACK_EN is undefined, the LoopBack port SHALL NOT exist and the receive path SHALL always use SPI_MISO.

Verification
REQ-026 DATA_W=8, ClkDiv=1, CPOL=0, CPHA=0, CsSel=2, TxData=0xA5, MISO driven by a slave model returning 0x3C -> MOSI carries 1010_0101, RxData=0x3C, Busy high for 36 cycles, only SPI_CS[2] low, one Done pulse.
REQ-027 All four CPOL/CPHA modes with TxData=0x81 against a mode-matched slave model -> RxData equals the slave word, and SPI_CLK idles at CPOL before and after each transfer.
REQ-028 Start pulsed again 5 cycles into a transfer with TxData=0xFF -> ignored, and the first word completes unchanged.
REQ-029 Done with IrqEnable=1 -> IrqPending=1 and Irq=1; IrqClear in the same cycle as a second Done -> IrqPending stays 1; IrqClear alone -> IrqPending=0.
REQ-030 Reset asserted at cycle 10 of a transfer -> all SPI_CS high and Busy=0 with no clock edge needed, and Done and IrqPending stay 0.
REQ-031 With SPI_MASTER_MULTI_LOOPBACK_EN defined, LoopBack=1, TxData=0x5A and MISO tied 0 -> RxData=0x5A.
